// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost direction scheduler.
package ghost_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam logic [31:0] DIST_MAX = 32'hFFFF_FFFF;

  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/ghost_dir_sched_if.sv
// Request/result bundle between ghost target logic and the direction scheduler.
// GHOST_FRIGHT_RAND_EN adds the frightened request bit.
interface ghost_dir_sched_if #(
  parameter int unsigned COORD_W = 10
);
  logic               start;
  logic [COORD_W-1:0] ghost_x;
  logic [COORD_W-1:0] ghost_y;
  logic [COORD_W-1:0] target_x;
  logic [COORD_W-1:0] target_y;
  logic [1:0]         cur_dir;
  logic [3:0]         wall_mask;
  logic               busy;
  logic               done;
  logic [1:0]         next_dir;
  logic [31:0]        dist_min;

`ifdef GHOST_FRIGHT_RAND_EN
  logic               frightened;

  modport master (
    output start, ghost_x, ghost_y, target_x, target_y, cur_dir, wall_mask, frightened,
    input  busy, done, next_dir, dist_min
  );
  modport slave (
    input  start, ghost_x, ghost_y, target_x, target_y, cur_dir, wall_mask, frightened,
    output busy, done, next_dir, dist_min
  );
`else
  modport master (
    output start, ghost_x, ghost_y, target_x, target_y, cur_dir, wall_mask,
    input  busy, done, next_dir, dist_min
  );
  modport slave (
    input  start, ghost_x, ghost_y, target_x, target_y, cur_dir, wall_mask,
    output busy, done, next_dir, dist_min
  );
`endif

endinterface

// File: rtl/findmin.sv
// Combinational minimum of four distances; ties go to the lowest index.
module findmin (
  input  logic [3:0][31:0] vals,
  output logic [1:0]       min_idx,
  output logic [31:0]      min_val
);

  always_comb begin
    min_idx = 2'd0;
    min_val = vals[0];
    for (int i = 1; i < 4; i++) begin
      if (vals[i] < min_val) begin
        min_idx = 2'(i);
        min_val = vals[i];
      end
    end
  end

endmodule

// File: rtl/ghost_dir_sched.sv
// Picks a ghost's next direction by squared distance to target, one squarer shared
// across the four candidates. GHOST_FRIGHT_RAND_EN enables the LFSR-driven frightened mode.
module ghost_dir_sched
  import ghost_pkg::*;
#(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned STEP    = 8
) (
  input logic               Clk,
  input logic               Reset,
  ghost_dir_sched_if.slave  bus
);

  localparam int unsigned CW = COORD_W + 2;
  localparam logic signed [CW-1:0] StepS = CW'(STEP);

  typedef enum logic [2:0] {StIdle, StSqX, StSqY, StDecide, StFinish} state_t;

  state_t             state_q;
  logic [COORD_W-1:0] gx_q, gy_q, tx_q, ty_q;
  dir_t               cur_q;
  logic [3:0]         valid_q;
  logic [1:0]         dir_q;
  logic [2*CW-1:0]    acc_q;
  logic [3:0][31:0]   dist_q;
  dir_t               best_dir_q;
  logic [31:0]        best_dist_q;
  logic               busy_q, done_q;
  dir_t               next_dir_q;
  logic [31:0]        dist_min_q;

  logic [3:0]             valid_new;
  logic signed [CW-1:0]   cand_x, cand_y, diff;
  logic [2*CW-1:0]        sq;
  logic [2*CW:0]          sum;
  logic [1:0]             fm_idx;
  logic [31:0]            fm_val;

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      valid_new[d] = ~bus.wall_mask[d] && (2'(d) != reverse_dir(dir_t'(bus.cur_dir)));
    end
  end

  // Candidate tile and shared squarer; SQ_Y squares dy, every other state squares dx.
  always_comb begin
    cand_x = signed'({2'b00, gx_q});
    cand_y = signed'({2'b00, gy_q});
    unique case (dir_q)
      2'd0:    cand_y = signed'({2'b00, gy_q}) - StepS;
      2'd1:    cand_x = signed'({2'b00, gx_q}) - StepS;
      2'd2:    cand_y = signed'({2'b00, gy_q}) + StepS;
      default: cand_x = signed'({2'b00, gx_q}) + StepS;
    endcase
    if (state_q == StSqY) diff = cand_y - signed'({2'b00, ty_q});
    else                  diff = cand_x - signed'({2'b00, tx_q});
    sq  = diff * diff;
    sum = {1'b0, acc_q} + {1'b0, sq};
  end

  findmin u_findmin (
    .vals    (dist_q),
    .min_idx (fm_idx),
    .min_val (fm_val)
  );

`ifdef GHOST_FRIGHT_RAND_EN
  logic [15:0] lfsr_q;
  logic [1:0]  lfsr_sel_q;
  logic        fr_q;
  logic [1:0]  rand_dir;

  always_ff @(posedge Clk) begin
    if (Reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // First valid direction at or after the sampled LFSR bits, wrapping around.
  always_comb begin
    rand_dir = lfsr_sel_q;
    for (int k = 3; k >= 0; k--) begin
      if (valid_q[2'(lfsr_sel_q + 2'(k))]) rand_dir = 2'(lfsr_sel_q + 2'(k));
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      gx_q        <= '0;
      gy_q        <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      cur_q       <= UP;
      valid_q     <= '0;
      dir_q       <= '0;
      acc_q       <= '0;
      dist_q      <= {4{DIST_MAX}};
      best_dir_q  <= UP;
      best_dist_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      next_dir_q  <= UP;
      dist_min_q  <= '0;
`ifdef GHOST_FRIGHT_RAND_EN
      lfsr_sel_q  <= '0;
      fr_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            gx_q    <= bus.ghost_x;
            gy_q    <= bus.ghost_y;
            tx_q    <= bus.target_x;
            ty_q    <= bus.target_y;
            cur_q   <= dir_t'(bus.cur_dir);
            valid_q <= valid_new;
            dir_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StSqX;
`ifdef GHOST_FRIGHT_RAND_EN
            lfsr_sel_q <= lfsr_q[1:0];
            fr_q       <= bus.frightened;
            if (bus.frightened) state_q <= StDecide;
`endif
          end
        end
        StSqX: begin
          acc_q   <= sq;
          state_q <= StSqY;
        end
        StSqY: begin
          dist_q[dir_q] <= valid_q[dir_q] ? 32'(sum) : DIST_MAX;
          if (dir_q == 2'd3) begin
            state_q <= StDecide;
          end else begin
            dir_q   <= dir_q + 2'd1;
            state_q <= StSqX;
          end
        end
        StDecide: begin
          if (valid_q == 4'b0000) begin
            best_dir_q  <= reverse_dir(cur_q);
            best_dist_q <= DIST_MAX;
          end else begin
            best_dir_q  <= dir_t'(fm_idx);
            best_dist_q <= fm_val;
`ifdef GHOST_FRIGHT_RAND_EN
            if (fr_q) begin
              best_dir_q  <= dir_t'(rand_dir);
              best_dist_q <= '0;
            end
`endif
          end
          state_q <= StFinish;
        end
        StFinish: begin
          next_dir_q <= best_dir_q;
          dist_min_q <= best_dist_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.next_dir = next_dir_q;
  assign bus.dist_min = dist_min_q;

endmodule

// File: tb/tb_ghost_dir_sched.sv
// Self-checking bench for ghost_dir_sched: behavioural model plus directed and random requests.
module tb_ghost_dir_sched;
  import ghost_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  ghost_dir_sched_if #(.COORD_W(10)) bus ();

  ghost_dir_sched #(
    .COORD_W (10),
    .STEP    (8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Squared Euclidean distance from candidate tile k to the target, in plain integers.
  function automatic int mdist(input int gx, input int gy, input int tx, input int ty, input int k);
    int cx, cy;
    cx = gx;
    cy = gy;
    case (k)
      0: cy = cy - 8;
      1: cx = cx - 8;
      2: cy = cy + 8;
      default: cx = cx + 8;
    endcase
    return (cx - tx) * (cx - tx) + (cy - ty) * (cy - ty);
  endfunction

  // Returns {direction, distance} for one decision.
  function automatic logic [33:0] pick(input int gx, input int gy, input int tx, input int ty,
                                       input logic [1:0] cd, input logic [3:0] wm,
                                       input bit fr, input logic [1:0] ls);
    logic [31:0] d [4];
    logic [3:0]  v;
    int          best;
    int          j;
    for (int k = 0; k < 4; k++) begin
      v[k] = !wm[k] && (k != int'(cd ^ 2'd2));
      d[k] = v[k] ? 32'(mdist(gx, gy, tx, ty, k)) : 32'hFFFF_FFFF;
    end
    if (v == 4'b0000) return {2'(cd ^ 2'd2), 32'hFFFF_FFFF};
    if (fr) begin
      for (int k = 0; k < 4; k++) begin
        j = (int'(ls) + k) % 4;
        if (v[j]) return {2'(j), 32'd0};
      end
    end
    best = 0;
    for (int k = 1; k < 4; k++) if (d[k] < d[best]) best = k;
    return {2'(best), d[best]};
  endfunction

  // Model state: cycles remaining until done, pending result, expected outputs.
  int          rem = 0;
  bit          armed = 1'b0;
  logic        exp_busy, exp_done;
  logic [1:0]  exp_dir, pend_dir;
  logic [31:0] exp_dist, pend_dist;
  logic [15:0] mlfsr;
  logic [33:0] res;

  // Inputs change just after posedge, so at negedge they are what the next posedge samples.
  always @(negedge Clk) begin
    if (armed) begin
      check("busy", 64'(bus.busy), 64'(exp_busy));
      check("done", 64'(bus.done), 64'(exp_done));
      check("next_dir", 64'(bus.next_dir), 64'(exp_dir));
      check("dist_min", 64'(bus.dist_min), 64'(exp_dist));
      if (bus.done === 1'b1) done_cnt++;
    end
    if (Reset === 1'b1) begin
      rem = 0; exp_busy = 0; exp_done = 0; exp_dir = 0; exp_dist = 0;
      mlfsr = 16'hACE1; armed = 1'b1;
    end else if (armed) begin
      exp_done = 1'b0;
      if (rem == 0) begin
        if (bus.start) begin
          bit fr;
`ifdef GHOST_FRIGHT_RAND_EN
          fr = bus.frightened;
`else
          fr = 1'b0;
`endif
          res = pick(int'(bus.ghost_x), int'(bus.ghost_y), int'(bus.target_x),
                     int'(bus.target_y), bus.cur_dir, bus.wall_mask, fr, mlfsr[1:0]);
          pend_dir  = res[33:32];
          pend_dist = res[31:0];
          rem = fr ? 2 : 10;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          exp_done = 1'b1;
          exp_dir  = pend_dir;
          exp_dist = pend_dist;
        end
      end
      exp_busy = (rem > 0);
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int gx, input int gy, input int tx, input int ty,
                         input logic [1:0] cd, input logic [3:0] wm);
    bus.ghost_x = 10'(gx); bus.ghost_y = 10'(gy);
    bus.target_x = 10'(tx); bus.target_y = 10'(ty);
    bus.cur_dir = cd; bus.wall_mask = wm;
  endtask

  // Pulses start (sampled at cycle 0) and returns the cycle done is seen, 0 on timeout.
  task automatic run_req(input bit repulse, output int cyc);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
      tick();
      bus.start = repulse && ((i + 1) == 3 || (i + 1) == 7);
      if (bus.start) bus.target_x = 10'd900;
    end
  endtask

  initial begin
    int cyc;
    int dc;
    Reset = 1'b1;
    bus.start = 1'b0;
`ifdef GHOST_FRIGHT_RAND_EN
    bus.frightened = 1'b0;
`endif
    set_req(0, 0, 0, 0, 2'd0, 4'd0);
    tick(); tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_dist", 64'(bus.dist_min), 64'd0);
    tick();

    check("model_up", 64'(mdist(100, 100, 200, 100, 0)), 64'd10064);
    check("model_right", 64'(mdist(100, 100, 200, 100, 3)), 64'd8464);
    check("model_left_tie", 64'(mdist(100, 100, 0, 0, 1)), 64'd18464);

    set_req(100, 100, 200, 100, 2'd3, 4'b0000);
    run_req(1'b0, cyc);
    check("t1_latency", 64'(cyc), 64'd11);
    check("t1_dir", 64'(bus.next_dir), 64'd3);
    check("t1_dist", 64'(bus.dist_min), 64'd8464);
    tick();

    set_req(100, 100, 0, 0, 2'd0, 4'b0000);
    run_req(1'b0, cyc);
    check("t2_dir", 64'(bus.next_dir), 64'd0);
    check("t2_dist", 64'(bus.dist_min), 64'd18464);
    tick();

    set_req(100, 100, 200, 100, 2'd3, 4'b1101);
    run_req(1'b0, cyc);
    check("deadend_dir", 64'(bus.next_dir), 64'd1);
    check("deadend_dist", 64'(bus.dist_min), 64'hFFFF_FFFF);
    tick();

    dc = done_cnt;
    set_req(100, 100, 200, 100, 2'd3, 4'b0000);
    run_req(1'b1, cyc);
    check("repulse_latency", 64'(cyc), 64'd11);
    check("repulse_dist", 64'(bus.dist_min), 64'd8464);
    for (int i = 0; i < 15; i++) tick();
    check("repulse_one_done", 64'(done_cnt - dc), 64'd1);

    // Reset at cycle 5 aborts the request without a done pulse.
    dc = done_cnt;
    set_req(300, 40, 10, 700, 2'd1, 4'b0010);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 15; i++) tick();
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);
    set_req(100, 100, 0, 0, 2'd0, 4'b0000);
    run_req(1'b0, cyc);
    check("after_abort_latency", 64'(cyc), 64'd11);
    check("after_abort_dist", 64'(bus.dist_min), 64'd18464);
    tick();

    // Random traffic: starts arrive at any time, occasional resets and dead ends.
    for (int n = 0; n < 4000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      bus.ghost_x  = (sel == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      bus.ghost_y  = (sel == 1) ? 10'($urandom_range(1008, 1023)) : 10'($urandom);
      bus.target_x = 10'($urandom);
      bus.target_y = (sel == 2) ? 10'(bus.ghost_y) : 10'($urandom);
      bus.cur_dir  = 2'($urandom);
      bus.wall_mask = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
      bus.start    = ($urandom_range(0, 3) == 0);
`ifdef GHOST_FRIGHT_RAND_EN
      bus.frightened = ($urandom_range(0, 2) == 0);
`endif
      Reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    bus.start = 1'b0;
    Reset = 1'b0;
    for (int i = 0; i < 15; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
